// File: rtl/ascon_pack.sv
// ascon_pack: definitions shared by the ASCON-128 encryption controller.
//   type_ctrl_state  controller state encoding
//   ROUND_*          round-counter load values and the final round index
//   is_round_state   true in every state where the permutation is clocked
package ascon_pack;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        P12_INIT,
        WAIT_AD,
        AD_FIRST,
        P6_AD,
        WAIT_PT,
        PT_FIRST,
        P6_PT,
        LAST_FIRST,
        P12_FIN,
        DONE
    } type_ctrl_state;

    localparam logic [3:0] ROUND_P12_START = 4'd0;
    localparam logic [3:0] ROUND_P6_START  = 4'd6;
    localparam logic [3:0] ROUND_LAST      = 4'd11;

    function automatic logic is_round_state(input type_ctrl_state s);
        return s inside {INIT, P12_INIT, AD_FIRST, P6_AD, PT_FIRST, P6_PT,
                         LAST_FIRST, P12_FIN};
    endfunction

endpackage

// File: rtl/round_counter.sv
// round_counter: 4-bit round-constant index for the ASCON permutation.
//   clock_i    system clock, rising edge
//   resetb_i   asynchronous active-low reset (counter -> 0)
//   load_i     synchronous load; has priority over inc_i
//   load_p6_i  load value select: 1 -> ROUND_P6_START, 0 -> ROUND_P12_START
//   inc_i      increment enable
//   round_o    current round index
module round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       load_i,
    input  logic       load_p6_i,
    input  logic       inc_i,
    output logic [3:0] round_o
);

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            round_o <= '0;
        end else if (load_i) begin
            round_o <= load_p6_i ? ROUND_P6_START : ROUND_P12_START;
        end else if (inc_i) begin
            round_o <= round_o + 4'd1;
        end
    end

endmodule

// File: rtl/ascon_ctrl.sv
// ascon_ctrl: Moore controller sequencing the ASCON-128 encryption datapath:
// Initialisation (p12), one AD block (p6), NB_BLOCKS plaintext blocks (p6
// between blocks, the last one feeding Finalisation p12).
//   clock_i / resetb_i   clock (rising edge) / async active-low reset
//   start_i              start an encryption, honoured in IDLE/DONE only
//   data_valid_i         AD or plaintext block present, honoured in WAIT_AD/WAIT_PT
//   round_o              round-constant index to the permutation
//   init_o               state mux selects IV||K||N
//   en_reg_state_o       state register load enable
//   en_xor_data_o        xor_begin: data into S0
//   en_xor_key_b_o       xor_begin: key into S1:S2 (finalisation)
//   en_xor_key_e_o       xor_end: key into S3:S4
//   en_xor_lsb_e_o       xor_end: 1 into S4 LSB
//   en_cipher_o          capture ciphertext register
//   cipher_valid_o       en_cipher_o delayed one cycle
//   tag_valid_o          one-cycle pulse on the first DONE cycle
//   block_cnt_o          index of the current plaintext block (saturating)
//   busy_o / end_o       outside IDLE/DONE / in DONE
module ascon_ctrl
    import ascon_pack::*;
#(
    parameter int unsigned NB_BLOCKS = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic             data_valid_i,
    output logic [3:0]       round_o,
    output logic             init_o,
    output logic             en_reg_state_o,
    output logic             en_xor_data_o,
    output logic             en_xor_key_b_o,
    output logic             en_xor_key_e_o,
    output logic             en_xor_lsb_e_o,
    output logic             en_cipher_o,
    output logic             cipher_valid_o,
    output logic             tag_valid_o,
    output logic [CNT_W-1:0] block_cnt_o,
    output logic             busy_o,
    output logic             end_o
);

    localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(NB_BLOCKS - 1);

    type_ctrl_state state;
    logic           rc_load;
    logic           rc_load_p6;
    logic           rc_inc;
    logic           round_last;
    logic           more_blocks;

    assign round_last  = (round_o == ROUND_LAST);
    assign more_blocks = (block_cnt_o < LAST_BLK);

    // Counter control uses the same input qualification as the state
    // transitions so that the round index is loaded on the entering edge.
    always_comb begin
        rc_load    = 1'b0;
        rc_load_p6 = 1'b0;
        unique case (state)
            IDLE, DONE: rc_load = start_i;
            WAIT_AD: begin
                rc_load    = data_valid_i;
                rc_load_p6 = 1'b1;
            end
            WAIT_PT: begin
                rc_load    = data_valid_i;
                rc_load_p6 = more_blocks;
            end
            default: ;
        endcase
        // Holding at the last round keeps round_o stable in the wait states.
        rc_inc = is_round_state(state) && !round_last;
    end

    round_counter u_round_counter (
        .clock_i   (clock_i),
        .resetb_i  (resetb_i),
        .load_i    (rc_load),
        .load_p6_i (rc_load_p6),
        .inc_i     (rc_inc),
        .round_o   (round_o)
    );

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state          <= IDLE;
            block_cnt_o    <= '0;
            cipher_valid_o <= 1'b0;
            tag_valid_o    <= 1'b0;
        end else begin
            cipher_valid_o <= en_cipher_o;
            // Registered so it lands exactly on the first DONE cycle.
            tag_valid_o    <= (state == P12_FIN) && round_last;
            unique case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state       <= INIT;
                        block_cnt_o <= '0;
                    end
                end
                INIT:       state <= P12_INIT;
                P12_INIT:   if (round_last) state <= WAIT_AD;
                WAIT_AD:    if (data_valid_i) state <= AD_FIRST;
                AD_FIRST:   state <= P6_AD;
                P6_AD:      if (round_last) state <= WAIT_PT;
                WAIT_PT: begin
                    if (data_valid_i) state <= more_blocks ? PT_FIRST : LAST_FIRST;
                end
                PT_FIRST:   state <= P6_PT;
                P6_PT: begin
                    if (round_last) begin
                        state <= WAIT_PT;
                        if (more_blocks) block_cnt_o <= block_cnt_o + 1'b1;
                    end
                end
                LAST_FIRST: state <= P12_FIN;
                P12_FIN:    if (round_last) state <= DONE;
                default:    state <= IDLE;
            endcase
        end
    end

    always_comb begin
        init_o         = (state == INIT);
        en_reg_state_o = is_round_state(state);
        en_xor_data_o  = (state == AD_FIRST) || (state == PT_FIRST) || (state == LAST_FIRST);
        en_xor_key_b_o = (state == LAST_FIRST);
        en_xor_key_e_o = ((state == P12_INIT) || (state == P12_FIN)) && round_last;
        en_xor_lsb_e_o = (state == P6_AD) && round_last;
        en_cipher_o    = (state == PT_FIRST) || (state == LAST_FIRST);
        busy_o         = (state != IDLE) && (state != DONE);
        end_o          = (state == DONE);
    end

endmodule

// File: tb/tb_ascon_ctrl.sv
// tb_ascon_ctrl: scoreboard bench for ascon_ctrl. Two instances: NB_BLOCKS=4
// (main) and NB_BLOCKS=1. Each scenario pushes per-cycle stimulus and the
// expected output vector derived from the documented state timeline, then
// drains the queues comparing the DUT one cycle at a time.
module tb_ascon_ctrl;

    typedef struct packed {
        logic [3:0] round;
        logic init, en_reg, xd, kb, ke, kl, ec, cv, tv, busy, fin;
        logic [2:0] cnt;
    } ov_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, dv = 1'b0, start1 = 1'b0, dv1 = 1'b0;
    logic sel = 1'b0;

    logic [3:0] round_a, round_b;
    logic init_a, reg_a, xd_a, kb_a, ke_a, kl_a, ec_a, cv_a, tv_a, busy_a, end_a;
    logic init_b, reg_b, xd_b, kb_b, ke_b, kl_b, ec_b, cv_b, tv_b, busy_b, end_b;
    logic [2:0] cnt_a;
    logic [0:0] cnt_b;

    ov_t  sb[$];
    logic [1:0] stim_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ascon_ctrl #(.NB_BLOCKS(4), .CNT_W(3)) dut (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start), .data_valid_i(dv),
        .round_o(round_a), .init_o(init_a), .en_reg_state_o(reg_a),
        .en_xor_data_o(xd_a), .en_xor_key_b_o(kb_a), .en_xor_key_e_o(ke_a),
        .en_xor_lsb_e_o(kl_a), .en_cipher_o(ec_a), .cipher_valid_o(cv_a),
        .tag_valid_o(tv_a), .block_cnt_o(cnt_a), .busy_o(busy_a), .end_o(end_a)
    );

    ascon_ctrl #(.NB_BLOCKS(1), .CNT_W(1)) dut1 (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start1), .data_valid_i(dv1),
        .round_o(round_b), .init_o(init_b), .en_reg_state_o(reg_b),
        .en_xor_data_o(xd_b), .en_xor_key_b_o(kb_b), .en_xor_key_e_o(ke_b),
        .en_xor_lsb_e_o(kl_b), .en_cipher_o(ec_b), .cipher_valid_o(cv_b),
        .tag_valid_o(tv_b), .block_cnt_o(cnt_b), .busy_o(busy_b), .end_o(end_b)
    );

    function automatic ov_t observe(input logic which);
        if (which)
            return {round_b, init_b, reg_b, xd_b, kb_b, ke_b, kl_b, ec_b, cv_b,
                    tv_b, busy_b, end_b, 2'b00, cnt_b};
        return {round_a, init_a, reg_a, xd_a, kb_a, ke_a, kl_a, ec_a, cv_a,
                tv_a, busy_a, end_a, cnt_a};
    endfunction

    // ---------------- expectation builders ----------------
    function automatic ov_t base(input logic [3:0] r, input logic [2:0] c);
        ov_t e = '0;
        e.round = r; e.cnt = c; e.busy = 1'b1;
        return e;
    endfunction

    task automatic push(input logic s, input logic d, input ov_t e);
        stim_q.push_back({s, d});
        sb.push_back(e);
    endtask

    task automatic drive(input logic [1:0] sd);
        if (sel) {start1, dv1} = sd;
        else     {start, dv}   = sd;
    endtask

    task automatic exp_idle(input int n, input logic [3:0] r, input logic [2:0] c,
                            input logic fin, input logic d);
        ov_t e = '0;
        e.round = r; e.cnt = c; e.fin = fin;
        for (int i = 0; i < n; i++) push(1'b0, d, e);
    endtask

    task automatic exp_wait(input int n, input logic [2:0] c, input logic s);
        for (int i = 0; i < n; i++) push(s, 1'b0, base(4'd11, c));
    endtask

    // start pulse -> INIT, rounds 1..11, then the first WAIT_AD cycle
    task automatic exp_p12_init(input logic [2:0] c);
        ov_t e = base(4'd0, c);
        e.init = 1'b1; e.en_reg = 1'b1;
        push(1'b1, 1'b0, e);
        for (int r = 1; r <= 11; r++) begin
            e = base(4'(r), c); e.en_reg = 1'b1; e.ke = (r == 11);
            push(1'b0, 1'b0, e);
        end
        push(1'b0, 1'b0, base(4'd11, c));
    endtask

    // data_valid -> *_FIRST (round 6), rounds 7..11, then one WAIT_PT cycle
    task automatic exp_p6(input logic [2:0] c, input logic pt, input logic spur_start);
        ov_t e = base(4'd6, c);
        e.en_reg = 1'b1; e.xd = 1'b1; e.ec = pt;
        push(1'b0, 1'b1, e);
        for (int r = 7; r <= 11; r++) begin
            e = base(4'(r), c); e.en_reg = 1'b1;
            e.cv = pt && (r == 7);
            e.kl = !pt && (r == 11);
            push(spur_start && (r == 9), 1'b0, e);
        end
        push(1'b0, 1'b0, base(4'd11, pt ? c + 3'd1 : c));
    endtask

    // data_valid -> LAST_FIRST (round 0), rounds 1..stop_r, then DONE cycles
    task automatic exp_fin(input logic [2:0] c, input logic spur_dv,
                           input int stop_r, input int n_done);
        ov_t e = base(4'd0, c);
        e.en_reg = 1'b1; e.xd = 1'b1; e.ec = 1'b1; e.kb = 1'b1;
        push(1'b0, 1'b1, e);
        for (int r = 1; r <= stop_r; r++) begin
            e = base(4'(r), c); e.en_reg = 1'b1;
            e.cv = (r == 1); e.ke = (r == 11);
            push(1'b0, spur_dv && (r == 5), e);
        end
        if (stop_r == 11) begin
            for (int i = 0; i < n_done; i++) begin
                e = '0; e.round = 4'd11; e.cnt = c; e.fin = 1'b1; e.tv = (i == 0);
                push(1'b0, 1'b0, e);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ov_t obs;
        #3;
        obs = observe(1'b0); n_cmp++;
        if (obs !== '0) begin n_err++; $display("FAIL reset_main: got %h want %h", obs, ov_t'('0)); end
        obs = observe(1'b1); n_cmp++;
        if (obs !== '0) begin n_err++; $display("FAIL reset_nb1: got %h want %h", obs, ov_t'('0)); end
        @(negedge clk); rst_n = 1'b1;
        exp_idle(3, 4'd0, 3'd0, 1'b0, 1'b1);   // data_valid in IDLE is ignored
        while (sb.size() != 0) begin
            @(negedge clk); drive(stim_q.pop_front());
            @(posedge clk); #1;
            obs = observe(sel); n_cmp++;
            if (obs !== sb[0]) begin n_err++; $display("FAIL idle_dv: got %h want %h", obs, sb[0]); end
            void'(sb.pop_front());
        end
    endtask

    task automatic test_init();
        ov_t obs, exp;
        int cyc = 0;
        exp_p12_init(3'd0);
        while (sb.size() != 0) begin
            @(negedge clk); drive(stim_q.pop_front());
            @(posedge clk); #1;
            exp = sb.pop_front(); obs = observe(sel); n_cmp++; cyc++;
            if (obs !== exp) begin n_err++; $display("FAIL init cyc%0d: got %h want %h", cyc, obs, exp); end
        end
    endtask

    task automatic test_ad();
        ov_t obs, exp;
        int cyc = 0;
        exp_wait(5, 3'd0, 1'b0);
        exp_p6(3'd0, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk); drive(stim_q.pop_front());
            @(posedge clk); #1;
            exp = sb.pop_front(); obs = observe(sel); n_cmp++; cyc++;
            if (obs !== exp) begin n_err++; $display("FAIL ad cyc%0d: got %h want %h", cyc, obs, exp); end
        end
    endtask

    task automatic test_message();
        ov_t obs, exp;
        int cyc = 0, n_cv = 0, n_tv = 0;
        exp_p6(3'd0, 1'b1, 1'b0);
        exp_wait(2, 3'd1, 1'b0);
        exp_p6(3'd1, 1'b1, 1'b0);
        exp_p6(3'd2, 1'b1, 1'b0);
        exp_fin(3'd3, 1'b0, 11, 3);
        while (sb.size() != 0) begin
            @(negedge clk); drive(stim_q.pop_front());
            @(posedge clk); #1;
            exp = sb.pop_front(); obs = observe(sel); n_cmp++; cyc++;
            if (obs !== exp) begin n_err++; $display("FAIL msg cyc%0d: got %h want %h", cyc, obs, exp); end
            n_cv += int'(obs.cv); n_tv += int'(obs.tv);
        end
        n_cmp++;
        if (n_cv != 4) begin n_err++; $display("FAIL msg_cv_count: got %0d want 4", n_cv); end
        n_cmp++;
        if (n_tv != 1) begin n_err++; $display("FAIL msg_tv_count: got %0d want 1", n_tv); end
    endtask

    task automatic test_ignored();
        ov_t obs, exp;
        int cyc = 0, n_cv = 0;
        exp_p12_init(3'd0);            // restart from DONE clears block_cnt
        exp_p6(3'd0, 1'b0, 1'b1);      // start during P6_AD
        exp_p6(3'd0, 1'b1, 1'b1);      // start during P6_PT
        exp_wait(1, 3'd1, 1'b1);       // start during WAIT_PT
        exp_p6(3'd1, 1'b1, 1'b0);
        exp_p6(3'd2, 1'b1, 1'b1);
        exp_fin(3'd3, 1'b1, 11, 2);    // data_valid during P12_FIN
        while (sb.size() != 0) begin
            @(negedge clk); drive(stim_q.pop_front());
            @(posedge clk); #1;
            exp = sb.pop_front(); obs = observe(sel); n_cmp++; cyc++;
            if (obs !== exp) begin n_err++; $display("FAIL ignore cyc%0d: got %h want %h", cyc, obs, exp); end
            n_cv += int'(obs.cv);
        end
        n_cmp++;
        if (n_cv != 4) begin n_err++; $display("FAIL ignore_cv_count: got %0d want 4", n_cv); end
    endtask

    task automatic test_reset_mid();
        ov_t obs, exp;
        int cyc = 0, n_cv = 0;
        exp_p12_init(3'd0);
        exp_p6(3'd0, 1'b0, 1'b0);
        exp_p6(3'd0, 1'b1, 1'b0);
        exp_p6(3'd1, 1'b1, 1'b0);
        exp_p6(3'd2, 1'b1, 1'b0);
        exp_fin(3'd3, 1'b0, 3, 0);
        while (sb.size() != 0) begin
            @(negedge clk); drive(stim_q.pop_front());
            @(posedge clk); #1;
            exp = sb.pop_front(); obs = observe(sel); n_cmp++; cyc++;
            if (obs !== exp) begin n_err++; $display("FAIL rmid_pre cyc%0d: got %h want %h", cyc, obs, exp); end
        end
        @(posedge clk); #1;
        obs = observe(sel); n_cmp++;
        if (obs.round !== 4'd4) begin n_err++; $display("FAIL rmid_round4: got %0d want 4", obs.round); end
        #2 rst_n = 1'b0;
        #1 obs = observe(sel); n_cmp++;
        if (obs !== '0) begin n_err++; $display("FAIL rmid_async: got %h want %h", obs, ov_t'('0)); end
        @(posedge clk); #1;
        obs = observe(sel); n_cmp++;
        if (obs !== '0) begin n_err++; $display("FAIL rmid_hold: got %h want %h", obs, ov_t'('0)); end
        @(negedge clk); rst_n = 1'b1;
        exp_idle(1, 4'd0, 3'd0, 1'b0, 1'b0);
        exp_p12_init(3'd0);
        exp_p6(3'd0, 1'b0, 1'b0);
        exp_p6(3'd0, 1'b1, 1'b0);
        exp_p6(3'd1, 1'b1, 1'b0);
        exp_p6(3'd2, 1'b1, 1'b0);
        exp_fin(3'd3, 1'b0, 11, 2);
        cyc = 0;
        while (sb.size() != 0) begin
            @(negedge clk); drive(stim_q.pop_front());
            @(posedge clk); #1;
            exp = sb.pop_front(); obs = observe(sel); n_cmp++; cyc++;
            if (obs !== exp) begin n_err++; $display("FAIL rmid_post cyc%0d: got %h want %h", cyc, obs, exp); end
            n_cv += int'(obs.cv);
        end
        n_cmp++;
        if (n_cv != 4) begin n_err++; $display("FAIL rmid_cv_count: got %0d want 4", n_cv); end
    endtask

    task automatic test_nb1();
        ov_t obs, exp;
        int cyc = 0, n_cv = 0, n_tv = 0;
        sel = 1'b1;
        exp_idle(1, 4'd0, 3'd0, 1'b0, 1'b0);
        exp_p12_init(3'd0);
        exp_p6(3'd0, 1'b0, 1'b0);
        exp_fin(3'd0, 1'b0, 11, 2);    // first plaintext goes straight to LAST_FIRST
        exp_p12_init(3'd0);            // restart from DONE
        while (sb.size() != 0) begin
            @(negedge clk); drive(stim_q.pop_front());
            @(posedge clk); #1;
            exp = sb.pop_front(); obs = observe(sel); n_cmp++; cyc++;
            if (obs !== exp) begin n_err++; $display("FAIL nb1 cyc%0d: got %h want %h", cyc, obs, exp); end
            n_cv += int'(obs.cv); n_tv += int'(obs.tv);
        end
        n_cmp++;
        if (n_cv != 1) begin n_err++; $display("FAIL nb1_cv_count: got %0d want 1", n_cv); end
        n_cmp++;
        if (n_tv != 1) begin n_err++; $display("FAIL nb1_tv_count: got %0d want 1", n_tv); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_ad();
        test_message();
        test_ignored();
        test_reset_mid();
        test_nb1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
